axi_id_prepend_mux: RTL and testbench

- Arbitrates NoSlvPorts AXI slave ports onto one AXI master port.
- Prepends the winning port index as the ID MSBs on AW/AR, and routes B/R back by stripping those MSBs.
- Sequences W beats through an AW-order FIFO.
- Sits between several masters and a single downstream crossbar or slave, as the controlling counterpart of the ID-prepend datapath.

---
 rtl/axi_id_prepend_mux.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_axi_id_prepend_mux.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_id_prepend_mux.sv
// ============================================================================
// Module   : axi_id_prepend_mux
// Purpose  : Round-robin multiplexer of NoSlvPorts AXI slave ports onto one
//            AXI master port. AW/AR IDs are widened by prepending the winning
//            port index; B/R are routed back by that index and the index bits
//            are stripped again. W beats follow AW order through a FIFO.
// Ports    : clk_i/rst_ni             clock, async active-low reset
//            slv_{aw,w,ar}_*          per-slave request channels (in)
//            slv_{b,r}_*              per-slave response channels (out)
//            mst_{aw,w,ar}_*          master request channels (out)
//            mst_{b,r}_*              master response channels (in)
// Notes    : Channel structs must be packed with the id field first (MSBs),
//            so prepending/stripping the index is a plain concat/truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_id_prepend_mux_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } slv_ax_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } mst_ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } slv_b_chan_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } mst_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } slv_r_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } mst_r_chan_t;
endpackage

module axi_id_prepend_mux
    import axi_id_prepend_mux_pkg::*;
#(
    parameter int unsigned NoSlvPorts        = 4,
    parameter int unsigned AxiIdWidthSlvPort = 4,
    parameter int unsigned AxiIdWidthMstPort = 6,
    parameter int unsigned MaxWTrans         = 8,
    parameter type slv_aw_chan_t = slv_ax_chan_t,
    parameter type slv_w_chan_t  = w_chan_t,
    parameter type slv_b_chan_t  = axi_id_prepend_mux_pkg::slv_b_chan_t,
    parameter type slv_ar_chan_t = slv_ax_chan_t,
    parameter type slv_r_chan_t  = axi_id_prepend_mux_pkg::slv_r_chan_t,
    parameter type mst_aw_chan_t = mst_ax_chan_t,
    parameter type mst_w_chan_t  = w_chan_t,
    parameter type mst_b_chan_t  = axi_id_prepend_mux_pkg::mst_b_chan_t,
    parameter type mst_ar_chan_t = mst_ax_chan_t,
    parameter type mst_r_chan_t  = axi_id_prepend_mux_pkg::mst_r_chan_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  slv_aw_chan_t          slv_aw_chans_i [NoSlvPorts],
    input  logic [NoSlvPorts-1:0] slv_aw_valids_i,
    output logic [NoSlvPorts-1:0] slv_aw_readies_o,
    input  slv_w_chan_t           slv_w_chans_i  [NoSlvPorts],
    input  logic [NoSlvPorts-1:0] slv_w_valids_i,
    output logic [NoSlvPorts-1:0] slv_w_readies_o,
    output slv_b_chan_t           slv_b_chans_o  [NoSlvPorts],
    output logic [NoSlvPorts-1:0] slv_b_valids_o,
    input  logic [NoSlvPorts-1:0] slv_b_readies_i,
    input  slv_ar_chan_t          slv_ar_chans_i [NoSlvPorts],
    input  logic [NoSlvPorts-1:0] slv_ar_valids_i,
    output logic [NoSlvPorts-1:0] slv_ar_readies_o,
    output slv_r_chan_t           slv_r_chans_o  [NoSlvPorts],
    output logic [NoSlvPorts-1:0] slv_r_valids_o,
    input  logic [NoSlvPorts-1:0] slv_r_readies_i,
    output mst_aw_chan_t          mst_aw_chan_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output mst_w_chan_t           mst_w_chan_o,
    output logic                  mst_w_valid_o,
    input  logic                  mst_w_ready_i,
    input  mst_b_chan_t           mst_b_chan_i,
    input  logic                  mst_b_valid_i,
    output logic                  mst_b_ready_o,
    output mst_ar_chan_t          mst_ar_chan_o,
    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    input  mst_r_chan_t           mst_r_chan_i,
    input  logic                  mst_r_valid_i,
    output logic                  mst_r_ready_o
);

    localparam int unsigned c_IDX_W = $clog2(NoSlvPorts);
    localparam int unsigned c_PTR_W = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
    localparam int unsigned c_CNT_W = $clog2(MaxWTrans + 1);

    if (NoSlvPorts < 2) begin : g_chk_ports
        $error("NoSlvPorts must be at least 2");
    end
    if (AxiIdWidthMstPort != AxiIdWidthSlvPort + c_IDX_W) begin : g_chk_idw
        $error("AxiIdWidthMstPort must equal AxiIdWidthSlvPort + clog2(NoSlvPorts)");
    end
    if ($bits(mst_aw_chan_t) != $bits(slv_aw_chan_t) + c_IDX_W) begin : g_chk_aw
        $error("AW channel widths inconsistent with index width");
    end

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} arb_state_e;

    // First requester at or after ptr, wrapping around the port count.
    function automatic logic [c_IDX_W-1:0] rr_pick(input logic [NoSlvPorts-1:0] req,
                                                   input logic [c_IDX_W-1:0]    ptr);
        logic [c_IDX_W-1:0] pick;
        logic [c_IDX_W-1:0] cand;
        pick = ptr;
        for (int i = NoSlvPorts - 1; i >= 0; i--) begin
            cand = c_IDX_W'((32'(ptr) + 32'(i)) % NoSlvPorts);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    function automatic logic [c_IDX_W-1:0] idx_inc(input logic [c_IDX_W-1:0] idx);
        return (32'(idx) == NoSlvPorts - 1) ? '0 : idx + c_IDX_W'(1);
    endfunction

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (32'(ptr) == MaxWTrans - 1) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------ W FIFO
    logic [c_IDX_W-1:0] r_fifo_mem [MaxWTrans];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_fifo_full, w_fifo_empty, w_push, w_pop;
    logic [c_IDX_W-1:0] w_head;

    // ---------------------------------------------------------------- AW arbiter
    arb_state_e         r_aw_state;
    logic [c_IDX_W-1:0] r_aw_idx, r_aw_ptr, w_aw_idx;
    logic               w_aw_valid, w_aw_hs;

    always_comb begin
        w_aw_idx   = rr_pick(slv_aw_valids_i, r_aw_ptr);
        w_aw_valid = (|slv_aw_valids_i) && !w_fifo_full;
        // Once offered, the grant is held so the master payload stays stable.
        if (r_aw_state == ST_LOCKED) begin
            w_aw_idx   = r_aw_idx;
            w_aw_valid = 1'b1;
        end
        w_aw_valid = w_aw_valid && rst_ni;
    end

    assign w_aw_hs        = w_aw_valid && mst_aw_ready_i;
    assign mst_aw_valid_o = w_aw_valid;
    assign mst_aw_chan_o  = mst_aw_chan_t'({w_aw_idx, slv_aw_chans_i[w_aw_idx]});

    always_comb begin
        slv_aw_readies_o           = '0;
        slv_aw_readies_o[w_aw_idx] = w_aw_hs;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_state <= ST_IDLE;
            r_aw_idx   <= '0;
            r_aw_ptr   <= '0;
        end else if (w_aw_hs) begin
            r_aw_state <= ST_IDLE;
            r_aw_ptr   <= idx_inc(w_aw_idx);
        end else if (w_aw_valid) begin
            r_aw_state <= ST_LOCKED;
            r_aw_idx   <= w_aw_idx;
        end
    end

    // ---------------------------------------------------------------- AR arbiter
    arb_state_e         r_ar_state;
    logic [c_IDX_W-1:0] r_ar_idx, r_ar_ptr, w_ar_idx;
    logic               w_ar_valid, w_ar_hs;

    always_comb begin
        w_ar_idx   = rr_pick(slv_ar_valids_i, r_ar_ptr);
        w_ar_valid = |slv_ar_valids_i;
        if (r_ar_state == ST_LOCKED) begin
            w_ar_idx   = r_ar_idx;
            w_ar_valid = 1'b1;
        end
        w_ar_valid = w_ar_valid && rst_ni;
    end

    assign w_ar_hs        = w_ar_valid && mst_ar_ready_i;
    assign mst_ar_valid_o = w_ar_valid;
    assign mst_ar_chan_o  = mst_ar_chan_t'({w_ar_idx, slv_ar_chans_i[w_ar_idx]});

    always_comb begin
        slv_ar_readies_o           = '0;
        slv_ar_readies_o[w_ar_idx] = w_ar_hs;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ar_state <= ST_IDLE;
            r_ar_idx   <= '0;
            r_ar_ptr   <= '0;
        end else if (w_ar_hs) begin
            r_ar_state <= ST_IDLE;
            r_ar_ptr   <= idx_inc(w_ar_idx);
        end else if (w_ar_valid) begin
            r_ar_state <= ST_LOCKED;
            r_ar_idx   <= w_ar_idx;
        end
    end

    // ---------------------------------------------------------- W order FIFO
    assign w_fifo_full  = (r_count == c_CNT_W'(MaxWTrans));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = w_aw_hs;
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_pop        = mst_w_valid_o && mst_w_ready_i && mst_w_chan_o.last;

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= w_aw_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // W beats are only steered from the FIFO head, which is written at the AW
    // handshake edge, so a beat can never overtake its own AW.
    assign mst_w_chan_o  = slv_w_chans_i[w_head];
    assign mst_w_valid_o = !w_fifo_empty && slv_w_valids_i[w_head];

    always_comb begin
        slv_w_readies_o = '0;
        if (!w_fifo_empty) slv_w_readies_o[w_head] = mst_w_ready_i;
    end

    // ---------------------------------------------------------- B/R routing
    logic [c_IDX_W-1:0] w_b_idx, w_r_idx;
    logic               w_b_in_range, w_r_in_range;

    assign w_b_idx      = mst_b_chan_i.id[AxiIdWidthMstPort-1:AxiIdWidthSlvPort];
    assign w_r_idx      = mst_r_chan_i.id[AxiIdWidthMstPort-1:AxiIdWidthSlvPort];
    assign w_b_in_range = (32'(w_b_idx) < NoSlvPorts);
    assign w_r_in_range = (32'(w_r_idx) < NoSlvPorts);

    // Responses carrying an index with no matching port are swallowed.
    always_comb begin
        slv_b_valids_o = '0;
        mst_b_ready_o  = 1'b1;
        if (w_b_in_range) begin
            slv_b_valids_o[w_b_idx] = mst_b_valid_i;
            mst_b_ready_o           = slv_b_readies_i[w_b_idx];
        end
    end

    always_comb begin
        slv_r_valids_o = '0;
        mst_r_ready_o  = 1'b1;
        if (w_r_in_range) begin
            slv_r_valids_o[w_r_idx] = mst_r_valid_i;
            mst_r_ready_o           = slv_r_readies_i[w_r_idx];
        end
    end

    for (genvar g = 0; g < NoSlvPorts; g++) begin : g_slv_resp
        assign slv_b_chans_o[g] = slv_b_chan_t'(mst_b_chan_i[$bits(slv_b_chan_t)-1:0]);
        assign slv_r_chans_o[g] = slv_r_chan_t'(mst_r_chan_i[$bits(slv_r_chan_t)-1:0]);
    end

`ifndef SYNTHESIS
    a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_aw_valid_o && !mst_aw_ready_i |=> mst_aw_valid_o && $stable(mst_aw_chan_o));
    a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_ar_valid_o && !mst_ar_ready_i |=> mst_ar_valid_o && $stable(mst_ar_chan_o));
    a_b_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_b_valid_i |-> w_b_in_range);
    a_r_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_r_valid_i |-> w_r_in_range);
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_id_prepend_mux.sv
// ============================================================================
// Module   : tb_axi_id_prepend_mux
// Purpose  : Self-checking bench for axi_id_prepend_mux (4 ports, 4->6 bit IDs)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_id_prepend_mux;
    import axi_id_prepend_mux_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    slv_ax_chan_t   slv_aw_chans [N];
    logic [N-1:0]   slv_aw_valids, slv_aw_readies;
    w_chan_t        slv_w_chans [N];
    logic [N-1:0]   slv_w_valids, slv_w_readies;
    slv_b_chan_t    slv_b_chans [N];
    logic [N-1:0]   slv_b_valids, slv_b_readies;
    slv_ax_chan_t   slv_ar_chans [N];
    logic [N-1:0]   slv_ar_valids, slv_ar_readies;
    slv_r_chan_t    slv_r_chans [N];
    logic [N-1:0]   slv_r_valids, slv_r_readies;
    mst_ax_chan_t   mst_aw_chan;
    logic           mst_aw_valid, mst_aw_ready;
    w_chan_t        mst_w_chan;
    logic           mst_w_valid, mst_w_ready;
    mst_b_chan_t    mst_b_chan;
    logic           mst_b_valid, mst_b_ready;
    mst_ax_chan_t   mst_ar_chan;
    logic           mst_ar_valid, mst_ar_ready;
    mst_r_chan_t    mst_r_chan;
    logic           mst_r_valid, mst_r_ready;

    axi_id_prepend_mux #(
        .NoSlvPorts(N), .AxiIdWidthSlvPort(4), .AxiIdWidthMstPort(6), .MaxWTrans(8),
        .slv_aw_chan_t(slv_ax_chan_t), .slv_w_chan_t(w_chan_t), .slv_b_chan_t(slv_b_chan_t),
        .slv_ar_chan_t(slv_ax_chan_t), .slv_r_chan_t(slv_r_chan_t),
        .mst_aw_chan_t(mst_ax_chan_t), .mst_w_chan_t(w_chan_t), .mst_b_chan_t(mst_b_chan_t),
        .mst_ar_chan_t(mst_ax_chan_t), .mst_r_chan_t(mst_r_chan_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_aw_chans_i(slv_aw_chans), .slv_aw_valids_i(slv_aw_valids), .slv_aw_readies_o(slv_aw_readies),
        .slv_w_chans_i(slv_w_chans), .slv_w_valids_i(slv_w_valids), .slv_w_readies_o(slv_w_readies),
        .slv_b_chans_o(slv_b_chans), .slv_b_valids_o(slv_b_valids), .slv_b_readies_i(slv_b_readies),
        .slv_ar_chans_i(slv_ar_chans), .slv_ar_valids_i(slv_ar_valids), .slv_ar_readies_o(slv_ar_readies),
        .slv_r_chans_o(slv_r_chans), .slv_r_valids_o(slv_r_valids), .slv_r_readies_i(slv_r_readies),
        .mst_aw_chan_o(mst_aw_chan), .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
        .mst_w_chan_o(mst_w_chan), .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
        .mst_b_chan_i(mst_b_chan), .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready),
        .mst_ar_chan_o(mst_ar_chan), .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
        .mst_r_chan_i(mst_r_chan), .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready)
    );

    int errors = 0;
    int checks = 0;

    mst_ax_chan_t exp_aw_q [$];
    mst_ax_chan_t exp_ar_q [$];
    w_chan_t      exp_w_q  [$];
    slv_r_chan_t  exp_r_q  [$];

    function automatic slv_ax_chan_t mk_slv(logic [3:0] id, logic [31:0] addr, logic [7:0] len);
        slv_ax_chan_t c;
        c.id = id; c.addr = addr; c.len = len;
        return c;
    endfunction

    function automatic mst_ax_chan_t mk_mst(logic [1:0] idx, logic [3:0] id, logic [31:0] addr,
                                           logic [7:0] len);
        mst_ax_chan_t c;
        c.id = {idx, id}; c.addr = addr; c.len = len;
        return c;
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < N; p++) begin
            slv_aw_chans[p] = '0; slv_w_chans[p] = '0; slv_ar_chans[p] = '0;
        end
        slv_aw_valids = '0; slv_w_valids = '0; slv_ar_valids = '0;
        slv_b_readies = '0; slv_r_readies = '0;
        mst_aw_ready = 1'b0; mst_w_ready = 1'b0; mst_ar_ready = 1'b0;
        mst_b_chan = '0; mst_b_valid = 1'b0; mst_r_chan = '0; mst_r_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        for (int p = 0; p < N; p++) slv_aw_chans[p] = mk_slv(4'(p + 1), 32'h100 * p, 8'd0);
        rst_n = 1'b0;
        slv_aw_valids = 4'b1111; slv_w_valids = 4'b1111; mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mst_aw_valid !== 1'b0) begin errors++; $display("FAIL reset_aw_valid: got %b want 0", mst_aw_valid); end
        checks++;
        if (slv_w_readies !== 4'b0000 || slv_aw_readies !== 4'b0000) begin
            errors++; $display("FAIL reset_readies: w=%b aw=%b want 0000", slv_w_readies, slv_aw_readies);
        end
        checks++;
        if (mst_w_valid !== 1'b0 || mst_ar_valid !== 1'b0) begin
            errors++; $display("FAIL reset_w_ar_valid: w=%b ar=%b want 0", mst_w_valid, mst_ar_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1; slv_w_valids = '0; mst_aw_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mst_aw_valid !== 1'b1 || mst_aw_chan !== mk_mst(2'd0, 4'd1, 32'h0, 8'd0)) begin
            errors++; $display("FAIL reset_first_grant: valid=%b chan=%h want 1 %h", mst_aw_valid,
                               mst_aw_chan, mk_mst(2'd0, 4'd1, 32'h0, 8'd0));
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ids [N];
        mst_ax_chan_t e;
        logic [1:0] order [5];
        ids = '{4'h3, 4'h9, 4'h5, 4'hC};
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        clear_inputs();
        for (int p = 0; p < N; p++) slv_aw_chans[p] = mk_slv(ids[p], 32'h1000 * (p + 1), 8'(p));
        do_reset();
        for (int k = 0; k < 5; k++)
            exp_aw_q.push_back(mk_mst(order[k], ids[order[k]], 32'h1000 * (order[k] + 1), 8'(order[k])));
        slv_aw_valids = 4'b1111; mst_aw_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && exp_aw_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (mst_aw_valid && mst_aw_ready) begin
                e = exp_aw_q.pop_front();
                checks++;
                if (mst_aw_chan !== e) begin
                    errors++; $display("FAIL rr_aw_chan: got %h want %h", mst_aw_chan, e);
                end
                checks++;
                if (slv_aw_readies !== (4'b0001 << e.id[5:4])) begin
                    errors++; $display("FAIL rr_aw_ready: got %b want port %0d", slv_aw_readies, e.id[5:4]);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_aw_q.size() != 0) begin
            errors++; $display("FAIL rr_timeout: %0d grants missing want 0", exp_aw_q.size());
            exp_aw_q.delete();
        end
        slv_aw_valids = '0;
    endtask

    task automatic test_aw_hold();
        mst_ax_chan_t e;
        clear_inputs();
        slv_aw_chans[0] = mk_slv(4'h7, 32'hA000, 8'd1);
        slv_aw_chans[1] = mk_slv(4'h2, 32'hB000, 8'd3);
        do_reset();
        exp_aw_q.push_back(mk_mst(2'd1, 4'h2, 32'hB000, 8'd3));
        exp_aw_q.push_back(mk_mst(2'd0, 4'h7, 32'hA000, 8'd1));
        slv_aw_valids = 4'b0010;
        next_cycle();
        slv_aw_valids = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (mst_aw_valid !== 1'b1 || mst_aw_chan !== exp_aw_q[0] || slv_aw_readies !== 4'b0000) begin
                errors++; $display("FAIL hold_stall: valid=%b chan=%h rdy=%b want 1 %h 0000",
                                   mst_aw_valid, mst_aw_chan, slv_aw_readies, exp_aw_q[0]);
            end
            next_cycle();
        end
        mst_aw_ready = 1'b1;
        for (int cyc = 0; cyc < 4 && exp_aw_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (mst_aw_valid && mst_aw_ready) begin
                e = exp_aw_q.pop_front();
                checks++;
                if (mst_aw_chan !== e || slv_aw_readies !== (4'b0001 << e.id[5:4])) begin
                    errors++; $display("FAIL hold_grant: chan=%h rdy=%b want %h port %0d",
                                       mst_aw_chan, slv_aw_readies, e, e.id[5:4]);
                end
            end
            next_cycle();
            slv_aw_valids = 4'b0001;
        end
        checks++;
        if (exp_aw_q.size() != 0) begin
            errors++; $display("FAIL hold_timeout: %0d grants missing want 0", exp_aw_q.size());
            exp_aw_q.delete();
        end
        slv_aw_valids = '0;
    endtask

    task automatic test_no_fallthrough();
        clear_inputs();
        slv_aw_chans[2] = mk_slv(4'h1, 32'h2000, 8'd0);
        slv_w_chans[2]  = '{data: 32'h1234_5678, strb: 4'hF, last: 1'b1};
        do_reset();
        slv_aw_valids = 4'b0100; slv_w_valids = 4'b0100; mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mst_aw_valid !== 1'b1 || slv_w_readies !== 4'b0000 || mst_w_valid !== 1'b0) begin
            errors++; $display("FAIL nft_same_cycle: aw=%b wrdy=%b wvalid=%b want 1 0000 0",
                               mst_aw_valid, slv_w_readies, mst_w_valid);
        end
        next_cycle();
        slv_aw_valids = '0;
        @(negedge clk);
        checks++;
        if (slv_w_readies !== 4'b0100 || mst_w_valid !== 1'b1 || mst_w_chan !== slv_w_chans[2]) begin
            errors++; $display("FAIL nft_next_cycle: wrdy=%b wvalid=%b want 0100 1", slv_w_readies, mst_w_valid);
        end
        next_cycle();
        slv_w_valids = '0;
        @(negedge clk);
        checks++;
        if (slv_w_readies !== 4'b0000 || mst_w_valid !== 1'b0) begin
            errors++; $display("FAIL nft_popped: wrdy=%b wvalid=%b want 0000 0", slv_w_readies, mst_w_valid);
        end
    endtask

    task automatic test_fifo_full();
        int hs;
        w_chan_t e;
        clear_inputs();
        slv_aw_chans[3] = mk_slv(4'h6, 32'h3000, 8'd0);
        slv_w_chans[0]  = '{data: 32'hDEAD_0000, strb: 4'hF, last: 1'b1};
        do_reset();
        slv_aw_valids = 4'b1000; slv_w_valids = 4'b0001; mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
        hs = 0;
        for (int cyc = 0; cyc < 20 && hs < 8; cyc++) begin
            @(negedge clk);
            if (mst_aw_valid && mst_aw_ready) hs++;
            next_cycle();
        end
        checks++;
        if (hs != 8) begin errors++; $display("FAIL fifo_fill: got %0d AW handshakes want 8", hs); end
        @(negedge clk);
        checks++;
        if (mst_aw_valid !== 1'b0) begin errors++; $display("FAIL fifo_full_block: aw_valid=%b want 0", mst_aw_valid); end
        checks++;
        if (slv_w_readies[0] !== 1'b0 || mst_w_valid !== 1'b0) begin
            errors++; $display("FAIL fifo_w_order: port0 rdy=%b wvalid=%b want 0 0", slv_w_readies[0], mst_w_valid);
        end
        next_cycle();
        slv_w_chans[3] = '{data: 32'hCAFE_0003, strb: 4'h5, last: 1'b1};
        slv_w_valids = 4'b1001;
        exp_w_q.push_back('{data: 32'hCAFE_0003, strb: 4'h5, last: 1'b1});
        @(negedge clk);
        if (mst_w_valid && mst_w_ready) begin
            e = exp_w_q.pop_front();
            checks++;
            if (mst_w_chan !== e || slv_w_readies !== 4'b1000) begin
                errors++; $display("FAIL fifo_w_beat: chan=%h rdy=%b want %h 1000", mst_w_chan, slv_w_readies, e);
            end
        end
        checks++;
        if (exp_w_q.size() != 0 || mst_aw_valid !== 1'b0) begin
            errors++; $display("FAIL fifo_w_pending: left=%0d aw_valid=%b want 0 0", exp_w_q.size(), mst_aw_valid);
            exp_w_q.delete();
        end
        next_cycle();
        slv_w_valids = 4'b0001;
        @(negedge clk);
        checks++;
        if (mst_aw_valid !== 1'b1 || mst_aw_chan !== mk_mst(2'd3, 4'h6, 32'h3000, 8'd0)) begin
            errors++; $display("FAIL fifo_ninth: valid=%b chan=%h want 1 %h", mst_aw_valid, mst_aw_chan,
                               mk_mst(2'd3, 4'h6, 32'h3000, 8'd0));
        end
        next_cycle();
        slv_aw_valids = '0; slv_w_valids = '0;
    endtask

    task automatic test_b_route();
        clear_inputs();
        do_reset();
        mst_b_chan = '{id: 6'h2A, resp: 2'b10}; mst_b_valid = 1'b1; slv_b_readies = 4'b1111;
        @(negedge clk);
        checks++;
        if (slv_b_valids !== 4'b0100 || mst_b_ready !== 1'b1) begin
            errors++; $display("FAIL b_route: valids=%b ready=%b want 0100 1", slv_b_valids, mst_b_ready);
        end
        checks++;
        if (slv_b_chans[2].id !== 4'hA || slv_b_chans[2].resp !== 2'b10) begin
            errors++; $display("FAIL b_strip: id=%h resp=%b want a 10", slv_b_chans[2].id, slv_b_chans[2].resp);
        end
        next_cycle();
        slv_b_readies = 4'b1011;
        @(negedge clk);
        checks++;
        if (mst_b_ready !== 1'b0) begin errors++; $display("FAIL b_backpressure: ready=%b want 0", mst_b_ready); end
        next_cycle();
        mst_b_chan = '{id: 6'h05, resp: 2'b00}; slv_b_readies = 4'b0001;
        @(negedge clk);
        checks++;
        if (slv_b_valids !== 4'b0001 || slv_b_chans[0].id !== 4'h5 || mst_b_ready !== 1'b1) begin
            errors++; $display("FAIL b_port0: valids=%b id=%h ready=%b want 0001 5 1",
                               slv_b_valids, slv_b_chans[0].id, mst_b_ready);
        end
        next_cycle();
        mst_b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (slv_b_valids !== 4'b0000) begin errors++; $display("FAIL b_idle: valids=%b want 0000", slv_b_valids); end
    endtask

    task automatic test_ar_r();
        mst_ax_chan_t ea;
        slv_r_chan_t  er;
        logic [31:0]  rdata [3];
        rdata = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
        clear_inputs();
        slv_ar_chans[0] = mk_slv(4'h1, 32'h4000, 8'd2);
        slv_ar_chans[1] = mk_slv(4'h2, 32'h5000, 8'd2);
        slv_aw_chans[1] = mk_slv(4'hE, 32'h6000, 8'd0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_ar_q.push_back((k % 2 == 0) ? mk_mst(2'd0, 4'h1, 32'h4000, 8'd2)
                                            : mk_mst(2'd1, 4'h2, 32'h5000, 8'd2));
            exp_aw_q.push_back(mk_mst(2'd1, 4'hE, 32'h6000, 8'd0));
        end
        for (int k = 0; k < 3; k++)
            exp_r_q.push_back('{id: 4'h3, data: rdata[k], resp: 2'b00, last: (k == 2)});
        slv_ar_valids = 4'b0011; slv_aw_valids = 4'b0010;
        mst_ar_ready = 1'b1; mst_aw_ready = 1'b1; slv_r_readies = 4'b1111;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 3) begin
                mst_r_chan  = '{id: 6'h13, data: rdata[cyc], resp: 2'b00, last: (cyc == 2)};
                mst_r_valid = 1'b1;
            end else begin
                mst_r_valid = 1'b0;
            end
            if (exp_ar_q.size() == 0) slv_ar_valids = '0;
            if (exp_aw_q.size() == 0) slv_aw_valids = '0;
            @(negedge clk);
            if (mst_ar_valid && mst_ar_ready && exp_ar_q.size() > 0) begin
                ea = exp_ar_q.pop_front();
                checks++;
                if (mst_ar_chan !== ea) begin errors++; $display("FAIL ar_grant: got %h want %h", mst_ar_chan, ea); end
            end
            if (mst_aw_valid && mst_aw_ready && exp_aw_q.size() > 0) begin
                ea = exp_aw_q.pop_front();
                checks++;
                if (mst_aw_chan !== ea) begin errors++; $display("FAIL ar_aw_grant: got %h want %h", mst_aw_chan, ea); end
            end
            if (mst_r_valid && mst_r_ready && exp_r_q.size() > 0) begin
                er = exp_r_q.pop_front();
                checks++;
                if (slv_r_valids !== 4'b0010 || slv_r_chans[1] !== er) begin
                    errors++; $display("FAIL r_route: valids=%b chan=%h want 0010 %h", slv_r_valids, slv_r_chans[1], er);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_ar_q.size() != 0 || exp_aw_q.size() != 0 || exp_r_q.size() != 0) begin
            errors++; $display("FAIL ar_r_timeout: ar=%0d aw=%0d r=%0d left want 0",
                               exp_ar_q.size(), exp_aw_q.size(), exp_r_q.size());
            exp_ar_q.delete(); exp_aw_q.delete(); exp_r_q.delete();
        end
        slv_ar_valids = '0; slv_aw_valids = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_aw_hold();
        test_no_fallthrough();
        test_fifo_full();
        test_b_route();
        test_ar_r();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
